// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment scan driver: hex-to-segment table
// (active-high, bit order {g,f,e,d,c,b,a}) and segment field positions.
package seg7_pkg;

    localparam int SEG_A = 0;
    localparam int SEG_B = 1;
    localparam int SEG_C = 2;
    localparam int SEG_D = 3;
    localparam int SEG_E = 4;
    localparam int SEG_F = 5;
    localparam int SEG_G = 6;

    typedef logic [SEG_G:SEG_A] seg_t;

    // Entry [h] is the active-high pattern for hex digit h.
    localparam logic [15:0][6:0] HEX_SEG = {
        7'b1110001, // F
        7'b1111001, // E
        7'b1011110, // d
        7'b0111001, // C
        7'b1111100, // b
        7'b1110111, // A
        7'b1101111, // 9
        7'b1111111, // 8
        7'b0000111, // 7
        7'b1111101, // 6
        7'b1101101, // 5
        7'b1100110, // 4
        7'b1001111, // 3
        7'b1011011, // 2
        7'b0000110, // 1
        7'b0111111  // 0
    };

    function automatic seg_t hex_to_seg(input logic [3:0] h);
        return HEX_SEG[h];
    endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex digit to active-high segment lookup.
// Ports: hex (4-bit digit in), seg ({g..a} active-high out).
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] hex,
    output seg_t       seg
);

    assign seg = hex_to_seg(hex);

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed DIGITS-digit 7-segment driver with frame snapshot,
// leading-zero blanking, per-digit DP, PWM brightness and dead-time.
// Ports: clk, rst (async high), EN, A (hex digits), DP_IN, LZB, BRIGHT;
// outputs NUM {g..a}, DP, AN (one-hot), FRAME (frame-start pulse).
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int DIGITS     = 4,
    parameter int DIV_W      = 10,
    parameter int BRIGHT_W   = 3,
    parameter int ACTIVE_LOW = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  EN,
    input  logic [4*DIGITS-1:0]   A,
    input  logic [DIGITS-1:0]     DP_IN,
    input  logic                  LZB,
    input  logic [BRIGHT_W-1:0]   BRIGHT,
    output logic [6:0]            NUM,
    output logic                  DP,
    output logic [DIGITS-1:0]     AN,
    output logic                  FRAME
);

    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic POL = (ACTIVE_LOW != 0);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

    logic [DIV_W-1:0]    div_cnt_q, div_cnt_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic                first_q, first_d;
    logic [4*DIGITS-1:0] a_s_q, a_s_d;
    logic [DIGITS-1:0]   dp_s_q, dp_s_d;
    logic                lzb_s_q, lzb_s_d;
    logic [BRIGHT_W-1:0] bright_s_q, bright_s_d;
    logic [6:0]          num_q, num_d;
    logic                dp_q, dp_d;
    logic [DIGITS-1:0]   an_q, an_d;
    logic                frame_q, frame_d;

    logic                tick;
    logic                frame_start;
    logic                run;
    logic [DIGITS-1:0]   blank;
    logic [3:0]          cur_digit;
    logic                cur_dp;
    logic                cur_blank;
    seg_t                cur_seg;
    logic                lit;
    logic [DIGITS-1:0]   an_raw;

    // Scan sequencing and frame snapshot. The first tick after reset is
    // a frame start that keeps idx at 0 so scanning begins on digit 0.
    always_comb begin
        tick        = &div_cnt_q;
        frame_start = tick && (first_q || idx_q == IDX_LAST);
        div_cnt_d   = div_cnt_q + 1'b1;
        idx_d       = idx_q;
        if (tick) begin
            idx_d = frame_start ? '0 : idx_q + 1'b1;
        end
        first_d    = first_q && !tick;
        a_s_d      = frame_start ? A      : a_s_q;
        dp_s_d     = frame_start ? DP_IN  : dp_s_q;
        lzb_s_d    = frame_start ? LZB    : lzb_s_q;
        bright_s_d = frame_start ? BRIGHT : bright_s_q;
    end

    // Walk from the top digit down; run stays set while every digit
    // seen so far is zero with no decimal point requested.
    always_comb begin
        run   = 1'b1;
        blank = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            run = run && (a_s_q[4*i +: 4] == 4'h0) && !dp_s_q[i];
            if (i > 0) begin
                blank[i] = lzb_s_q && run;
            end
        end
    end

    always_comb begin
        cur_digit = '0;
        cur_dp    = 1'b0;
        cur_blank = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                cur_digit = a_s_q[4*i +: 4];
                cur_dp    = dp_s_q[i];
                cur_blank = blank[i];
            end
        end
    end

    seg7_hex_decode u_dec (
        .hex (cur_digit),
        .seg (cur_seg)
    );

    // div_cnt==0 is the dead-time cycle; PWM compares the top bits.
    always_comb begin
        lit = EN && (div_cnt_q != '0)
            && (div_cnt_q[DIV_W-1 -: BRIGHT_W] < bright_s_q);
        an_raw  = lit ? (DIGITS'(1) << idx_q) : '0;
        an_d    = an_raw ^ {DIGITS{POL}};
        num_d   = (cur_blank ? 7'h00 : cur_seg) ^ {7{POL}};
        dp_d    = cur_dp ^ POL;
        frame_d = frame_start;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt_q  <= '0;
            idx_q      <= '0;
            first_q    <= 1'b1;
            a_s_q      <= '0;
            dp_s_q     <= '0;
            lzb_s_q    <= 1'b0;
            bright_s_q <= '0;
            num_q      <= {7{POL}};
            dp_q       <= POL;
            an_q       <= {DIGITS{POL}};
            frame_q    <= 1'b0;
        end else begin
            div_cnt_q  <= div_cnt_d;
            idx_q      <= idx_d;
            first_q    <= first_d;
            a_s_q      <= a_s_d;
            dp_s_q     <= dp_s_d;
            lzb_s_q    <= lzb_s_d;
            bright_s_q <= bright_s_d;
            num_q      <= num_d;
            dp_q       <= dp_d;
            an_q       <= an_d;
            frame_q    <= frame_d;
        end
    end

    assign NUM   = num_q;
    assign DP    = dp_q;
    assign AN    = an_q;
    assign FRAME = frame_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver (DIGITS=4, DIV_W=4,
// BRIGHT_W=2, ACTIVE_LOW=1) plus a DIGITS=3 instance.
module tb_seg7_scan_driver;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en = 1'b0;
    logic        lzb = 1'b0;
    logic [15:0] a = '0;
    logic [3:0]  dp_in = '0;
    logic [1:0]  bright = '0;
    logic [6:0]  num;
    logic        dp;
    logic [3:0]  an;
    logic        frame;

    logic [11:0] a3 = 12'h123;
    logic [6:0]  num3;
    logic        dp3;
    logic [2:0]  an3;
    logic        frame3;

    always #5 clk = ~clk;

    seg7_scan_driver #(
        .DIGITS(4), .DIV_W(4), .BRIGHT_W(2), .ACTIVE_LOW(1)
    ) dut (
        .clk(clk), .rst(rst), .EN(en), .A(a), .DP_IN(dp_in),
        .LZB(lzb), .BRIGHT(bright), .NUM(num), .DP(dp),
        .AN(an), .FRAME(frame)
    );

    seg7_scan_driver #(
        .DIGITS(3), .DIV_W(4), .BRIGHT_W(2), .ACTIVE_LOW(1)
    ) dut3 (
        .clk(clk), .rst(rst), .EN(1'b1), .A(a3), .DP_IN(3'b000),
        .LZB(1'b0), .BRIGHT(2'd3), .NUM(num3), .DP(dp3),
        .AN(an3), .FRAME(frame3)
    );

    typedef struct packed {
        logic [15:0]     a;
        logic [3:0]      dpi;
        logic            lzb;
        logic [1:0]      br;
        logic [3:0][6:0] num;
        logic [3:0]      dp;
        logic [3:0]      on;
    } vec_t;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] num;
        logic       dp;
        logic [3:0] on;
    } slot_t;

    vec_t  vecs[8];
    slot_t sb[$];
    int    vectors = 0;
    int    miscompares = 0;

    function automatic vec_t mk(
        input logic [15:0] a_, input logic [3:0] dpi,
        input logic lz, input logic [1:0] br,
        input logic [6:0] n3, input logic [6:0] n2,
        input logic [6:0] n1, input logic [6:0] n0,
        input logic [3:0] dpx, input logic [3:0] on
    );
        vec_t v;
        v.a   = a_;
        v.dpi = dpi;
        v.lzb = lz;
        v.br  = br;
        v.num = {n3, n2, n1, n0};
        v.dp  = dpx;
        v.on  = on;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_frame(input bit three, output int cyc);
        cyc = 0;
        repeat (200) begin
            @(posedge clk);
            #1;
            cyc++;
            if ((three ? frame3 : frame) === 1'b1) return;
        end
        cyc = -1;
    endtask

    task automatic drive_vec(input vec_t v);
        logic [3:0] one;
        slot_t s;
        @(negedge clk);
        a      = v.a;
        dp_in  = v.dpi;
        lzb    = v.lzb;
        bright = v.br;
        en     = 1'b1;
        for (int k = 0; k < 4; k++) begin
            one   = 4'b0001 << k;
            s.an  = ~one;
            s.num = v.num[k];
            s.dp  = v.dp[k];
            s.on  = v.on;
            sb.push_back(s);
        end
    endtask

    // Called right after a FRAME sample; walks the four 16-cycle slots.
    task automatic observe_frame(input string tag);
        slot_t      s;
        int         on;
        bit         bad;
        logic [6:0] nv;
        logic       dv;
        for (int k = 0; k < 4; k++) begin
            if (sb.size() == 0) begin
                chk($sformatf("%s slot%0d empty", tag, k), 0, 1);
                continue;
            end
            s   = sb.pop_front();
            on  = 0;
            bad = 1'b0;
            nv  = '0;
            dv  = 1'b0;
            for (int d = 0; d < 16; d++) begin
                @(posedge clk);
                #1;
                if (an === s.an) begin
                    on++;
                    if (d == 0) bad = 1'b1;
                end else if (an !== 4'hf) begin
                    bad = 1'b1;
                end
                if (d == 8) begin
                    nv = num;
                    dv = dp;
                end
            end
            chk($sformatf("%s slot%0d", tag, k),
                {19'd0, bad, 4'(on), nv, dv},
                {19'd0, 1'b0, s.on, s.num, s.dp});
        end
    endtask

    initial begin
        int c;
        int n;
        int bad;
        int fbad;
        bit seen;
        logic [2:0] one3;
        logic [2:0] exp3;

        vecs[0] = mk(16'h1208, 4'b0000, 1'b0, 2'd3,
            7'b1111001, 7'b0100100, 7'b1000000, 7'b0000000, 4'b1111, 4'd11);
        vecs[1] = mk(16'h0005, 4'b0000, 1'b1, 2'd3,
            7'b1111111, 7'b1111111, 7'b1111111, 7'b0010010, 4'b1111, 4'd11);
        vecs[2] = mk(16'h0005, 4'b0100, 1'b1, 2'd3,
            7'b1111111, 7'b1000000, 7'b1000000, 7'b0010010, 4'b1011, 4'd11);
        vecs[3] = mk(16'h1208, 4'b0001, 1'b0, 2'd0,
            7'b1111001, 7'b0100100, 7'b1000000, 7'b0000000, 4'b1110, 4'd0);
        vecs[4] = mk(16'hABCD, 4'b0000, 1'b0, 2'd1,
            7'b0001000, 7'b0000011, 7'b1000110, 7'b0100001, 4'b1111, 4'd3);
        vecs[5] = mk(16'hF3E9, 4'b1111, 1'b1, 2'd2,
            7'b0001110, 7'b0110000, 7'b0000110, 7'b0010000, 4'b0000, 4'd7);
        vecs[6] = mk(16'h0000, 4'b0000, 1'b1, 2'd3,
            7'b1111111, 7'b1111111, 7'b1111111, 7'b1000000, 4'b1111, 4'd11);
        vecs[7] = mk(16'h7604, 4'b0000, 1'b0, 2'd3,
            7'b1111000, 7'b0000010, 7'b1000000, 7'b0011001, 4'b1111, 4'd11);

        // Reset state, before any clock edge.
        #2 rst = 1'b1;
        #1;
        chk("reset", {18'd0, an, num, dp, frame},
            {18'd0, 4'hf, 7'h7f, 1'b1, 1'b0});
        chk("reset3", {19'd0, an3, num3, dp3, frame3},
            {19'd0, 3'h7, 7'h7f, 1'b1, 1'b0});

        // First frame after release: snapshot on the first tick.
        repeat (2) @(negedge clk);
        drive_vec(vecs[0]);
        rst = 1'b0;
        wait_frame(1'b0, c);
        chk("first_frame_cyc", c, 16);
        observe_frame("vec0");

        for (int i = 1; i < 8; i++) begin
            drive_vec(vecs[i]);
            wait_frame(1'b0, c);
            chk($sformatf("vec%0d frame_period", i), c, 64);
            observe_frame($sformatf("vec%0d", i));
        end

        // Mid-frame change of A is held off until the next frame.
        @(negedge clk);
        a = 16'h1111; bright = 2'd3; lzb = 1'b0; dp_in = '0; en = 1'b1;
        wait_frame(1'b0, c);
        chk("midframe_wait", c, 64);
        bad = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (num !== 7'b1111001) bad++;
        end
        @(negedge clk);
        a = 16'h2222;
        seen = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(posedge clk);
            #1;
            if (num !== 7'b1111001) bad++;
            if (frame === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        chk("midframe_hold", bad, 0);
        chk("midframe_frame", 32'(seen), 1);
        @(posedge clk);
        #1;
        chk("midframe_switch", {24'd0, frame, num},
            {24'd0, 1'b0, 7'b0100100});

        // EN dropped mid-slot; scanning cadence must not change.
        wait_frame(1'b0, c);
        chk("en_frame_wait", c, 63);
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        en = 1'b0;
        bad = 0;
        repeat (5) begin
            @(posedge clk);
            #1;
            if (an !== 4'hf) bad++;
        end
        chk("en_off", bad, 0);
        @(negedge clk);
        en = 1'b1;
        @(posedge clk);
        #1;
        chk("en_resume", an, 4'b1110);
        wait_frame(1'b0, c);
        chk("en_period", 11 + c, 64);

        // Asynchronous reset between clock edges, mid-slot.
        wait_frame(1'b0, c);
        repeat (6) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("async_rst", {18'd0, an, num, dp, frame},
            {18'd0, 4'hf, 7'h7f, 1'b1, 1'b0});
        chk("async_rst3", {19'd0, an3, num3, dp3, frame3},
            {19'd0, 3'h7, 7'h7f, 1'b1, 1'b0});
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        n = 0;
        for (int k = 0; k < 100; k++) begin
            @(posedge clk);
            #1;
            n++;
            if (an !== 4'hf) break;
        end
        chk("rst_first_an", an, 4'b1110);
        chk("rst_first_cyc", n, 18);

        // DIGITS=3 instance: three slots per frame, 48-cycle frames.
        wait_frame(1'b1, c);
        chk("d3_frame_wait", c, 46);
        bad = 0;
        fbad = 0;
        for (int k = 0; k < 96; k++) begin
            @(posedge clk);
            #1;
            one3 = 3'b001 << ((k / 16) % 3);
            exp3 = ((k % 16) != 0 && (k % 16) < 12) ? ~one3 : 3'b111;
            if (an3 !== exp3) bad++;
            if (frame3 !== ((k == 47) || (k == 95))) fbad++;
        end
        chk("d3_scan", bad, 0);
        chk("d3_frame_period", fbad, 0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
Parametrised time-multiplexed 7-segment display driver that scans DIGITS hex digits onto shared segment lines with one-hot anode select. It is the next-generation encapsulating display driver for the board's display. It adds these features:
- frame-coherent snapshot of the display value
- leading-zero blanking
- per-digit decimal point
- PWM brightness
- anode dead-time between slots (anti-ghosting)
- frame-start strobe

It sits between the elevator controller's floor/status value and the board display pins.

Parameters:
DIGITS, 4, number of multiplexed digits (>=2)
DIV_W, 10, slot length is 2**DIV_W clk cycles per digit
BRIGHT_W, 3, brightness resolution in bits; must be < DIV_W
ACTIVE_LOW, 1, 1 = segments/anodes/DP driven low-true (board default); 0 = high-true

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-high reset
EN  input  1  display enable; 0 = all anodes inactive
A  input  4*DIGITS  hex value; digit i = A[4i+3:4i]; digit 0 is rightmost
DP_IN  input  DIGITS  decimal point request per digit
LZB  input  1  leading-zero blanking enable
BRIGHT  input  BRIGHT_W  brightness level; 0 = dark, max = brightest
NUM  output  7  segments {g,f,e,d,c,b,a}
DP  output  1  decimal point segment
AN  output  DIGITS  one-hot anode select
FRAME  output  1  one-cycle pulse at frame start

Behaviour:
- Reset is asynchronous and active-high. On reset:
  - div_cnt=0, idx=0
  - all snapshots=0
  - NUM, DP and AN all inactive (all 1s when ACTIVE_LOW=1)
  - FRAME=0
- div_cnt is a free-running DIV_W-bit counter.
- Slot tick: div_cnt == all ones.
  - On tick, idx increments; it wraps from DIGITS-1 to 0.
  - DIGITS need not be a power of two; idx never exceeds DIGITS-1.
- Frame start: the tick on which idx wraps to 0 (and the first tick after reset).
  - A, DP_IN, LZB and BRIGHT are captured into snapshot registers.
  - FRAME is high for exactly the following cycle.
  - Inputs changing mid-frame have no visible effect until the next frame.
- Leading-zero blanking, computed from the snapshot:
  - Digit i is blanked iff LZB_s=1, i>0, and all snapshot digits j>=i are 0 with no DP_s bit set for any j>=i.
  - Digit 0 is never blanked.
  - A blanked digit drives NUM inactive; its anode still follows the PWM rule, so its DP still shows if requested.
- Anode timing within the current slot:
  - AN[idx] is active iff EN=1, div_cnt != 0, and div_cnt[DIV_W-1 -: BRIGHT_W] < BRIGHT_s.
  - div_cnt==0 is a mandatory dead-time cycle: all anodes are inactive.
  - BRIGHT_s=0: all anodes are always inactive.
  - At most one anode is active in any cycle.
- Decode:
  - NUM = hex_to_seg(snapshot digit idx) unless blanked.
  - DP = DP_s[idx].
  - Both are inverted when ACTIVE_LOW=1.
- Latency: NUM, DP, AN and FRAME are registered, one cycle after the div_cnt/idx state that produced them. No combinational path from inputs to outputs.
- EN deassert: anodes go inactive within one cycle; counters and snapshots keep running. Re-enabling resumes without a restart.
- Reset asserted mid-slot: outputs are forced inactive immediately (async). After release, scanning restarts at idx=0 with a fresh snapshot on the first tick.

Decomposition:
- Shared package seg7_pkg holds:
  - the 16-entry hex-to-segment constant table, active-high {g..a}: 0=0111111, 1=0000110, 8=1111111, F=1110001
  - the segment field order constants
- Sub-module seg7_hex_decode: combinational 4-bit to 7-bit active-high lookup from seg7_pkg. The top level applies polarity and blanking.

Test Plan:
Bench configuration: DIGITS=4, DIV_W=4, BRIGHT_W=2, ACTIVE_LOW=1 unless noted.

1. Reset then A=16'h1208, BRIGHT=3, EN=1, LZB=0 -> anodes cycle 1110, 1101, 1011, 0111 with 16-cycle slots and cycle 0 of each slot all 1111. NUM per slot = 0000000 (8), 1000000 (0), 0100100 (2), 1111001 (1). FRAME pulses every 64 cycles.
2. A=16'h0005, LZB=1, DP_IN=0 -> digits 3..1 show NUM=1111111, digit 0 shows 0010010. With DP_IN=4'b0100, digits 2..1 unblank as 0 and DP=0 in digit 2's slot.
3. BRIGHT sweep 0,1,2,3 -> per-slot active-anode cycles = 0, 3, 7, 11. BRIGHT=0 keeps AN=1111 permanently.
4. A changed from 16'h1111 to 16'h2222 mid-frame -> NUM continues showing 1 for the rest of the frame and switches to 2 only after the next FRAME pulse.
5. EN low for 5 cycles mid-slot -> AN=1111 one cycle after deassert. idx/div_cnt are unaffected, confirmed by FRAME period staying 64.
6. rst pulsed mid-slot, asynchronously between clock edges -> AN/NUM/DP=all 1s before the next edge. After release, first active anode is 1110; DIGITS=3 variant never asserts idx 3.
